// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: d-side priority with bounded i-side starvation.
// Optional `ARB_STATS_EN adds icount/dcount/stallcnt counters.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [31:0]       stallcnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;
    localparam logic [3:0] W_MAX      = 4'(MAX_DSTREAK);

    state_t     r_state;
    logic [3:0] r_streak;

    logic w_dreq;
    logic w_acc;
    logic w_err;
    logic w_idone;
    logic w_ddone;
    logic w_iforce;

    assign w_dreq   = dREN | dWEN;
    assign w_acc    = (ramstate == RAM_ACCESS);
    assign w_err    = (ramstate == RAM_ERROR);
    assign w_idone  = (r_state == IGRANT) && iREN && w_acc;
    assign w_ddone  = (r_state == DGRANT) && w_dreq && w_acc;
    assign w_iforce = iREN && (r_streak == W_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_dreq && !w_iforce) begin
                        r_state <= DGRANT;
                    end else if (iREN) begin
                        r_state <= IGRANT;
                    end
                end
                IGRANT: begin
                    if (!iREN) begin
                        r_state <= IDLE;
                    end else if (w_acc) begin
                        r_state  <= IDLE;
                        r_streak <= '0;
                    end else if (w_err) begin
                        r_state <= IDLE;
                    end
                end
                DGRANT: begin
                    if (!w_dreq) begin
                        r_state <= IDLE;
                    end else if (w_acc) begin
                        r_state <= IDLE;
                        // Count d-wins only while the i-side is actually waiting
                        if (!iREN) begin
                            r_streak <= '0;
                        end else if (r_streak != W_MAX) begin
                            r_streak <= r_streak + 4'd1;
                        end
                    end else if (w_err) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        unique case (r_state)
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (w_idone) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (w_ddone) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_icount;
    logic [31:0] r_dcount;
    logic [31:0] r_stallcnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount   <= '0;
            r_dcount   <= '0;
            r_stallcnt <= '0;
        end else begin
            if (w_idone) r_icount <= r_icount + 32'd1;
            if (w_ddone) r_dcount <= r_dcount + 32'd1;
            if (iREN && iwait) r_stallcnt <= r_stallcnt + 32'd1;
        end
    end

    assign icount   = r_icount;
    assign dcount   = r_dcount;
    assign stallcnt = r_stallcnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Stats checks run only when ARB_STATS_EN is defined.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam logic [1:0] FREE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] ERR  = 2'b11;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic [AW-1:0] iload;
    logic          iwait;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [AW-1:0] dstore;
    logic [AW-1:0] dload;
    logic          dwait;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [AW-1:0] ramstore;
    logic [AW-1:0] ramload;
    logic [1:0]    ramstate;
`ifdef ARB_STATS_EN
    logic [31:0]   icount;
    logic [31:0]   dcount;
    logic [31:0]   stallcnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .MAX_DSTREAK(4)) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iload   (iload),
        .iwait   (iwait),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dload   (dload),
        .dwait   (dwait),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate)
`ifdef ARB_STATS_EN
        ,
        .icount  (icount),
        .dcount  (dcount),
        .stallcnt(stallcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_all();
        iREN = 0; dREN = 0; dWEN = 0;
        ramstate = FREE; ramload = '0;
    endtask

    task automatic stats_iacc(input logic [AW-1:0] a);
        iREN = 1; iaddr = a; ramstate = BUSY;
        cyc();
        cyc();
        ramstate = ACC; ramload = 32'h1111_0000 | a;
        cyc();
        idle_all();
    endtask

    task automatic stats_dacc(input logic [AW-1:0] a);
        dREN = 1; daddr = a; ramstate = ACC;
        cyc();
        cyc();
        idle_all();
    endtask

    int dn;
    int got_i;
    int both;

    initial begin
        nRST = 0; iaddr = '0; daddr = '0; dstore = '0;
        idle_all();
        #1;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        cyc(); cyc();
        nRST = 1;
        cyc();

        // Lone i-read with two BUSY cycles
        iREN = 1; iaddr = 32'h40; ramstate = BUSY;
        #1;
        chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
        cyc(); #1;
        chk("t1_b1_ramREN", 32'(ramREN), 32'd1);
        chk("t1_b1_ramaddr", ramaddr, 32'h40);
        chk("t1_b1_iwait", 32'(iwait), 32'd1);
        cyc(); #1;
        chk("t1_b2_ramREN", 32'(ramREN), 32'd1);
        chk("t1_b2_iwait", 32'(iwait), 32'd1);
        cyc();
        ramstate = ACC; ramload = 32'hDEADBEEF;
        #1;
        chk("t1_acc_iwait", 32'(iwait), 32'd0);
        chk("t1_acc_iload", iload, 32'hDEADBEEF);
        chk("t1_acc_dwait", 32'(dwait), 32'd1);
        cyc();
        idle_all();
        #1;
        chk("t1_post_ramREN", 32'(ramREN), 32'd0);

        // Simultaneous i-read and d-write: d wins
        cyc();
        iREN = 1; iaddr = 32'h40;
        dWEN = 1; daddr = 32'h100; dstore = 32'h5; ramstate = BUSY;
        #1;
        chk("t2_idle_ramWEN", 32'(ramWEN), 32'd0);
        cyc();
        ramstate = ACC;
        #1;
        chk("t2_d_ramWEN", 32'(ramWEN), 32'd1);
        chk("t2_d_ramREN", 32'(ramREN), 32'd0);
        chk("t2_d_ramaddr", ramaddr, 32'h100);
        chk("t2_d_ramstore", ramstore, 32'h5);
        chk("t2_d_dwait", 32'(dwait), 32'd0);
        chk("t2_d_iwait", 32'(iwait), 32'd1);
        cyc();
        dWEN = 0; ramstate = BUSY;
        #1;
        chk("t2_gap_ramREN", 32'(ramREN), 32'd0);
        chk("t2_gap_ramWEN", 32'(ramWEN), 32'd0);
        chk("t2_gap_iwait", 32'(iwait), 32'd1);
        cyc();
        ramstate = ACC; ramload = 32'h0BADF00D;
        #1;
        chk("t2_i_ramaddr", ramaddr, 32'h40);
        chk("t2_i_iwait", 32'(iwait), 32'd0);
        chk("t2_i_iload", iload, 32'h0BADF00D);
        cyc();
        idle_all();

        // Streak: 4 d-wins, then i forced; twice to show the streak cleared
        cyc();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h200;
        ramstate = ACC; ramload = 32'h77;
        for (int r = 0; r < 2; r++) begin
            dn = 0; got_i = 0; both = 0;
            #1;
            for (int k = 0; k < 40; k++) begin
                if (!iwait && !dwait) both++;
                if (!dwait) dn++;
                if (!iwait) begin
                    got_i = 1;
                    break;
                end
                cyc(); #1;
            end
            chk("t3_dcount", 32'(dn), 32'd4);
            chk("t3_igrant", 32'(got_i), 32'd1);
            chk("t3_dREN_held", 32'(dREN), 32'd1);
            chk("t3_both_low", 32'(both), 32'd0);
            cyc();
        end
        idle_all();

        // ERROR during DGRANT, then retry
        cyc();
        dREN = 1; daddr = 32'h300; ramstate = ERR;
        cyc(); #1;
        chk("t4_err_ramREN", 32'(ramREN), 32'd1);
        chk("t4_err_dwait", 32'(dwait), 32'd1);
        cyc(); #1;
        chk("t4_idle_ramREN", 32'(ramREN), 32'd0);
        chk("t4_idle_dwait", 32'(dwait), 32'd1);
        cyc();
        ramstate = ACC; ramload = 32'h1234;
        #1;
        chk("t4_re_ramaddr", ramaddr, 32'h300);
        chk("t4_re_dwait", 32'(dwait), 32'd0);
        chk("t4_re_dload", dload, 32'h1234);
        cyc();
        idle_all();

        // Reset mid-IGRANT while BUSY
        cyc();
        iREN = 1; iaddr = 32'h88; ramstate = BUSY;
        cyc(); #1;
        chk("t5_pre_ramREN", 32'(ramREN), 32'd1);
        nRST = 0;
        #1;
        chk("t5_rst_ramREN", 32'(ramREN), 32'd0);
        chk("t5_rst_iwait", 32'(iwait), 32'd1);
        cyc();
        nRST = 1;
        cyc();
        ramstate = ACC; ramload = 32'hCAFE;
        #1;
        chk("t5_after_ramaddr", ramaddr, 32'h88);
        chk("t5_after_iwait", 32'(iwait), 32'd0);
        chk("t5_after_iload", iload, 32'hCAFE);
        cyc();
        idle_all();

`ifdef ARB_STATS_EN
        cyc();
        nRST = 0;
        #1;
        chk("st_rst_icount", icount, 32'd0);
        chk("st_rst_stall", stallcnt, 32'd0);
        cyc();
        nRST = 1;
        cyc();
        stats_iacc(32'h10);
        stats_dacc(32'h20);
        stats_iacc(32'h14);
        stats_dacc(32'h24);
        stats_iacc(32'h18);
        #1;
        chk("st_icount", icount, 32'd3);
        chk("st_dcount", dcount, 32'd2);
        chk("st_stallcnt", stallcnt, 32'd6);
`endif

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
